// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

  localparam int DW = 32;
  localparam int AW = 4;

  // r15 is the program counter and is not stored in the register file
  localparam logic [AW-1:0] PC_REG = 4'hF;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries (register address + data).
// Latency: an entry pushed at edge N is visible at the head after edge N.
// Backpressure: push is ignored while full, pop is ignored while empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_entry_t              push_dat,
  input  logic                   pop,
  output wb_entry_t              head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign full     = (r_count == FULL_CNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign head_dat = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even when it pops in the same cycle
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Payload storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Arbitrates ALU results (buffered) and load responses onto the single regfile write port; r15 goes to the PC port.
// Latency: load accepted at edge N writes at edge N; ALU pushed at edge N writes at edge N+1 at the earliest.
// Backpressure: alu_ready/ld_ready drop only while the ALU FIFO is full. Optional WB_SCOREBOARD_EN builds the load-busy scoreboard.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [AW-1:0]          ld_rd,
  input  logic [DW-1:0]          ld_data,
  input  logic                   ld_issue,
  input  logic [AW-1:0]          ld_issue_rd,
  output logic                   we3,
  output logic [AW-1:0]          wa3,
  output logic [DW-1:0]          wd3,
  output logic                   pc_we,
  output logic [DW-1:0]          pc_wd,
  output logic [14:0]            busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  wb_entry_t         w_alu_ent;
  wb_entry_t         w_ld_ent;
  wb_entry_t         w_head;
  wb_entry_t         w_sel;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ld_acc;
  logic              w_wr_vld;

  logic              r_we3;
  logic [AW-1:0]     r_wa3;
  logic [DW-1:0]     r_wd3;
  logic              r_pc_we;
  logic [DW-1:0]     r_pc_wd;

  // Readies depend on occupancy only, so there is no valid-to-ready path
  assign alu_ready = !w_full;
  assign ld_ready  = !w_full;

  assign w_alu_ent = {alu_rd, alu_data};
  assign w_ld_ent  = {ld_rd, ld_data};
  assign w_push    = alu_valid && !w_full;
  assign w_ld_acc  = ld_valid && !w_full;

  // Full FIFO drains first; otherwise a pending load wins and the FIFO waits
  assign w_pop    = w_full || (!ld_valid && !w_empty);
  assign w_wr_vld = w_ld_acc || w_pop;
  assign w_sel    = w_ld_acc ? w_ld_ent : w_head;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_dat (w_alu_ent),
    .pop      (w_pop),
    .head_dat (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (fifo_count)
  );

  // Register the selected write; r15 is routed to the PC port, addresses/data hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we3   <= 1'b0;
      r_wa3   <= '0;
      r_wd3   <= '0;
      r_pc_we <= 1'b0;
      r_pc_wd <= '0;
    end else begin
      r_we3   <= 1'b0;
      r_pc_we <= 1'b0;
      if (w_wr_vld) begin
        if (w_sel.rd == PC_REG) begin
          r_pc_we <= 1'b1;
          r_pc_wd <= w_sel.data;
        end else begin
          r_we3 <= 1'b1;
          r_wa3 <= w_sel.rd;
          r_wd3 <= w_sel.data;
        end
      end
    end
  end

  assign we3   = r_we3;
  assign wa3   = r_wa3;
  assign wd3   = r_wd3;
  assign pc_we = r_pc_we;
  assign pc_wd = r_pc_wd;

`ifdef WB_SCOREBOARD_EN
  logic [14:0] r_busy;
  logic [14:0] w_set;
  logic [14:0] w_clr;

  // Decode masks for issued loads (set) and accepted responses (clear); r15 never matches
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < 15; i++) begin
      if (ld_issue && (ld_issue_rd == AW'(i))) w_set[i] = 1'b1;
      if (w_ld_acc && (ld_rd == AW'(i)))       w_clr[i] = 1'b1;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign busy = r_busy;
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{ld_issue, ld_issue_rd};
  assign busy        = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes are queued as stimulus is issued, a monitor checks them.
// Latency: outputs sampled on the falling edge after each active edge.
// Backpressure: drivers hold payloads until the sampled ready allows a transfer.
module tb_regfile_writeback;

  typedef struct packed {
    logic        pc;
    logic [3:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_issue;
  logic [3:0]  ld_issue_rd;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        pc_we;
  logic [31:0] pc_wd;
  logic [14:0] busy;
  logic [2:0]  fifo_count;

  int   total;
  int   bad;
  exp_t q[$];

  regfile_writeback #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .pc_we       (pc_we),
    .pc_wd       (pc_wd),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic pc, input logic [3:0] rd, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.rd   = rd;
    e.data = data;
    q.push_back(e);
  endtask

  // Monitor: every write the DUT presents must match the head of the expectation queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (we3 || pc_we)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got we3=%0b pc_we=%0b wa3=%0h wd3=%0h pc_wd=%0h want no write",
                 we3, pc_we, wa3, wd3, pc_wd);
      end else begin
        e = q.pop_front();
        if (e.pc) begin
          check("wb_pc_we", pc_we, 1);
          check("wb_we3_low", we3, 0);
          check("wb_pc_wd", pc_wd, e.data);
        end else begin
          check("wb_we3", we3, 1);
          check("wb_pc_we_low", pc_we, 0);
          check("wb_wa3", wa3, e.rd);
          check("wb_wd3", wd3, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ai;
    int li;
    int step;
    logic a_x;
    logic l_x;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0;  ld_rd = 0;  ld_data = 0;
    ld_issue = 0;  ld_issue_rd = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we3", we3, 0);
    check("rst_pc_we", pc_we, 0);
    check("rst_count", fifo_count, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single ALU write: r3 = DEADBEEF, one cycle through the FIFO
    alu_valid = 1; alu_rd = 4'd3; alu_data = 32'hDEADBEEF;
    expect_wr(0, 4'd3, 32'hDEADBEEF);
    @(negedge clk);
    alu_valid = 0;
    check("alu_no_bypass", we3, 0);
    check("alu_count1", fifo_count, 1);
    @(negedge clk);
    check("alu_count0", fifo_count, 0);
    @(negedge clk);
    check("alu_we3_drop", we3, 0);

    // Load priority: load r5 beats ALU r2 on the same edge
    alu_valid = 1; alu_rd = 4'd2; alu_data = 32'h22222222;
    ld_valid  = 1; ld_rd  = 4'd5; ld_data  = 32'h00001234;
    expect_wr(0, 4'd5, 32'h00001234);
    expect_wr(0, 4'd2, 32'h22222222);
    @(negedge clk);
    alu_valid = 0; ld_valid = 0;
    check("prio_count", fifo_count, 1);
    repeat (2) @(negedge clk);

    // PC route: load to r15 goes to pc port, wa3/wd3 keep last regfile write
    ld_valid = 1; ld_rd = 4'd15; ld_data = 32'h00000100;
    expect_wr(1, 4'd15, 32'h00000100);
    @(negedge clk);
    ld_valid = 0;
    check("pc_wa3_hold", wa3, 4'd2);
    check("pc_wd3_hold", wd3, 32'h22222222);
    @(negedge clk);
    check("pc_we_drop", pc_we, 0);

    // FIFO full: loads every cycle, 5 ALU results, DEPTH 4
    foreach (q[i]) check("q_empty_before_full", q.size(), 0);
    for (int i = 0; i < 4; i++) expect_wr(0, 4'(i + 8), 32'hB0000000 + i);
    expect_wr(0, 4'd1, 32'hA0000000);
    expect_wr(0, 4'd12, 32'hB0000004);
    expect_wr(0, 4'd2, 32'hA0000001);
    expect_wr(0, 4'd13, 32'hB0000005);
    expect_wr(0, 4'd3, 32'hA0000002);
    expect_wr(0, 4'd4, 32'hA0000003);
    expect_wr(0, 4'd5, 32'hA0000004);
    ai = 0; li = 0; step = 0;
    while ((ai < 5 || li < 6) && step < 40) begin
      alu_valid = (ai < 5); alu_rd = 4'(ai + 1); alu_data = 32'hA0000000 + ai;
      ld_valid  = (li < 6); ld_rd  = 4'(li + 8); ld_data  = 32'hB0000000 + li;
      if (step == 4) begin
        check("full_count4", fifo_count, 4);
        check("full_alu_ready", alu_ready, 0);
        check("full_ld_ready", ld_ready, 0);
      end
      if (step == 5) begin
        check("full_count3", fifo_count, 3);
        check("full_ld_ready_back", ld_ready, 1);
      end
      a_x = alu_valid && alu_ready;
      l_x = ld_valid && ld_ready;
      @(negedge clk);
      if (a_x) ai++;
      if (l_x) li++;
      step++;
    end
    alu_valid = 0; ld_valid = 0;
    check("full_alu_sent", ai, 5);
    check("full_ld_sent", li, 6);
    check("full_steps", step, 8);
    repeat (5) @(negedge clk);
    check("full_drained", fifo_count, 0);

    // Reset mid-stream with 3 entries buffered
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 4'(i + 1); alu_data = 32'hC0000000 + i;
      ld_valid  = 1; ld_rd  = 4'(i + 9); ld_data  = 32'hD0000000 + i;
      expect_wr(0, 4'(i + 9), 32'hD0000000 + i);
      @(negedge clk);
    end
    alu_valid = 0; ld_valid = 0;
    check("mid_count3", fifo_count, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_we3", we3, 0);
    check("mid_wa3", wa3, 0);
    check("mid_wd3", wd3, 0);
    check("mid_pc_we", pc_we, 0);
    check("mid_pc_wd", pc_wd, 0);
    check("mid_busy", busy, 0);
    check("mid_count0", fifo_count, 0);
    check("mid_alu_ready", alu_ready, 1);
    check("mid_ld_ready", ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_we3", we3, 0);
    check("post_rst_pc_we", pc_we, 0);
    check("post_rst_count", fifo_count, 0);
    repeat (3) @(negedge clk);

    // Scoreboard
`ifdef WB_SCOREBOARD_EN
    ld_issue = 1; ld_issue_rd = 4'd7;
    @(negedge clk);
    ld_issue = 0;
    check("sb_set7", busy, 15'h0080);
    ld_issue = 1; ld_issue_rd = 4'd7;
    ld_valid = 1; ld_rd = 4'd7; ld_data = 32'h00000077;
    expect_wr(0, 4'd7, 32'h00000077);
    @(negedge clk);
    ld_issue = 0; ld_valid = 0;
    check("sb_set_wins", busy, 15'h0080);
    ld_valid = 1; ld_rd = 4'd7; ld_data = 32'h00000078;
    expect_wr(0, 4'd7, 32'h00000078);
    @(negedge clk);
    ld_valid = 0;
    check("sb_clear7", busy, 15'h0000);
    ld_issue = 1; ld_issue_rd = 4'd15;
    @(negedge clk);
    ld_issue = 0;
    check("sb_r15_ignored", busy, 15'h0000);
`else
    ld_issue = 1; ld_issue_rd = 4'd7;
    @(negedge clk);
    ld_issue = 0;
    check("sb_disabled", busy, 15'h0000);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
